// File: rtl/trng_sample_ctrl.sv
// rtl/trng_sample_ctrl.sv - RO entropy sequencer: warm-up, paced sample strobes, 1-entry word buffer.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_sample_ctrl #(
    parameter int SAMPLE_DIV    = 16,
    parameter int WARMUP_CYCLES = 256,
    parameter int RCT_LIMIT     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        raw_bit,
    output logic        ro_en,
    output logic        coll_clr,
    output logic        sample_bit,
    output logic        sample_valid,
    input  logic [63:0] word_in,
    input  logic        word_in_valid,
    output logic [63:0] word_out,
    output logic        word_out_valid,
    input  logic        word_out_ready,
    output logic        busy,
    output logic        overflow,
    output logic        health_fail
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int WU_W  = $clog2(WARMUP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WU_W-1:0]  WU_LAST    = WU_W'(WARMUP_CYCLES - 1);

    if (SAMPLE_DIV < 2 || WARMUP_CYCLES < 1 || RCT_LIMIT < 2) begin : g_bad_param
        $error("trng_sample_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    logic [WU_W-1:0]   r_wu_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [5:0]        r_bit_cnt;
    logic              r_ro_en;
    logic              r_coll_clr;
    logic              r_sample_bit;
    logic              r_sample_valid;
    logic              r_busy;
    logic [63:0]       r_word_out;
    logic              r_word_out_valid;
    logic              r_overflow;

    state_t            w_state_nxt;
    logic [WU_W-1:0]   w_wu_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [5:0]        w_bit_nxt;
    logic              w_strobe;
    logic              w_abort;
    logic              w_rct_trip;
    logic              w_start_ok;

`ifdef TRNG_HEALTH_EN
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);
    localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_LIMIT);

    logic [RCT_W-1:0] r_rct_cnt;
    logic             r_health_fail;

    assign w_rct_trip  = (r_rct_cnt == RCT_MAX);
    assign w_start_ok  = !r_health_fail;
    assign health_fail = r_health_fail;

    // rct_cnt==0 marks "no previous bit yet", so the first strobe after a start counts as 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rct_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_abort) begin
                r_rct_cnt <= '0;
            end else if (w_strobe) begin
                if (r_rct_cnt == '0 || raw_bit != r_sample_bit) begin
                    r_rct_cnt <= RCT_W'(1);
                end else if (r_rct_cnt != RCT_MAX) begin
                    r_rct_cnt <= r_rct_cnt + RCT_W'(1);
                end
            end
            if (w_abort && w_rct_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end
`else
    assign w_rct_trip  = 1'b0;
    assign w_start_ok  = 1'b1;
    assign health_fail = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wu_nxt    = r_wu_cnt;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_strobe    = 1'b0;
        w_abort     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_wu_nxt = '0;
                if (start && !stop && w_start_ok) begin
                    w_state_nxt = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (r_wu_cnt == WU_LAST) begin
                    w_state_nxt = S_SAMPLE;
                    w_wu_nxt    = '0;
                    w_div_nxt   = DIV_RELOAD;
                end else begin
                    w_wu_nxt = r_wu_cnt + WU_W'(1);
                end
            end
            S_SAMPLE: begin
                if (r_div_cnt != '0) begin
                    w_div_nxt = r_div_cnt - DIV_W'(1);
                end else if (r_bit_cnt == 6'd63 && r_word_out_valid) begin
                    // Completing this word now would collide with the still-full buffer
                    w_state_nxt = S_HOLD;
                end else begin
                    w_strobe = 1'b1;
                end
            end
            S_HOLD: begin
                if (!r_word_out_valid) begin
                    w_state_nxt = S_SAMPLE;
                    w_strobe    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_strobe) begin
            w_div_nxt = DIV_RELOAD;
            w_bit_nxt = r_bit_cnt + 6'd1;
        end

        if ((stop || w_rct_trip) && r_state != S_IDLE) begin
            w_abort     = 1'b1;
            w_strobe    = 1'b0;
            w_state_nxt = S_IDLE;
            w_wu_nxt    = '0;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wu_cnt       <= '0;
            r_div_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_ro_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_coll_clr     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_bit   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wu_cnt       <= w_wu_nxt;
            r_div_cnt      <= w_div_nxt;
            r_bit_cnt      <= w_bit_nxt;
            r_ro_en        <= (w_state_nxt != S_IDLE);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_coll_clr     <= w_abort;
            r_sample_valid <= w_strobe;
            if (w_strobe) begin
                r_sample_bit <= raw_bit;
            end
        end
    end

    // A word arriving into a full, non-draining buffer is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_out       <= '0;
            r_word_out_valid <= 1'b0;
            r_overflow       <= 1'b0;
        end else if (word_in_valid) begin
            if (!r_word_out_valid || word_out_ready) begin
                r_word_out       <= word_in;
                r_word_out_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_word_out_valid && word_out_ready) begin
            r_word_out_valid <= 1'b0;
        end
    end

    assign ro_en          = r_ro_en;
    assign busy           = r_busy;
    assign coll_clr       = r_coll_clr;
    assign sample_valid   = r_sample_valid;
    assign sample_bit     = r_sample_bit;
    assign word_out       = r_word_out;
    assign word_out_valid = r_word_out_valid;
    assign overflow       = r_overflow;

endmodule
